iq_deinterleave: RTL

//   Front-end producer for the I/Q datapath: pops a byte stream from one FWFT FIFO,

---
 rtl/iq_deinterleave.sv | 113 +++++++++++
 1 files changed

// File: rtl/iq_deinterleave.sv
// Byte-stream to I/Q sample deinterleaver: pops 4 bytes per pair, quantizes both samples
// (<< BITS) and pushes them into the I and Q FIFOs together. Optional macro: IQ_BIG_ENDIAN_EN.
module iq_deinterleave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] I_din,
  input  logic                  I_full,
  output logic                  I_wr_en,
  output logic [DATA_WIDTH-1:0] Q_din,
  input  logic                  Q_full,
  output logic                  Q_wr_en
);

  localparam int unsigned SAMPLE_W = 2 * BYTE_WIDTH;

  typedef enum logic [2:0] {
    S_I_LO  = 3'd0,
    S_I_HI  = 3'd1,
    S_Q_LO  = 3'd2,
    S_Q_HI  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [BYTE_WIDTH-1:0] r_i_lo;
  logic [BYTE_WIDTH-1:0] r_i_hi;
  logic [BYTE_WIDTH-1:0] r_q_first;
  logic [DATA_WIDTH-1:0] r_i_din;
  logic [DATA_WIDTH-1:0] r_q_din;
  logic [SAMPLE_W-1:0]   w_i_raw;
  logic [SAMPLE_W-1:0]   w_q_raw;
  logic                  w_pop;
  logic                  w_push;

`ifdef IQ_BIG_ENDIAN_EN
  localparam state_t FIRST_ST   = S_I_HI;
  localparam state_t Q_FIRST_ST = S_Q_HI;
  localparam state_t LAST_ST    = S_Q_LO;
  assign w_q_raw = {r_q_first, in_dout};
`else
  localparam state_t FIRST_ST   = S_I_LO;
  localparam state_t Q_FIRST_ST = S_Q_LO;
  localparam state_t LAST_ST    = S_Q_HI;
  assign w_q_raw = {in_dout, r_q_first};
`endif

  assign w_i_raw = {r_i_hi, r_i_lo};

  // Sign-extend to the output width, then arithmetic shift into fixed point.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [SAMPLE_W-1:0] s);
    logic signed [DATA_WIDTH-1:0] ext;
    ext = DATA_WIDTH'($signed(s));
    return ext <<< BITS;
  endfunction

  assign w_pop    = !reset && !in_empty && (r_state != S_WRITE);
  assign w_push   = !reset && (r_state == S_WRITE) && !I_full && !Q_full;
  assign in_rd_en = w_pop;
  assign I_wr_en  = w_push;
  assign Q_wr_en  = w_push;
  assign I_din    = r_i_din;
  assign Q_din    = r_q_din;

  always_comb begin
    w_next = FIRST_ST;
    case (r_state)
`ifdef IQ_BIG_ENDIAN_EN
      S_I_HI:  w_next = S_I_LO;
      S_I_LO:  w_next = S_Q_HI;
      S_Q_HI:  w_next = S_Q_LO;
      S_Q_LO:  w_next = S_WRITE;
`else
      S_I_LO:  w_next = S_I_HI;
      S_I_HI:  w_next = S_Q_LO;
      S_Q_LO:  w_next = S_Q_HI;
      S_Q_HI:  w_next = S_WRITE;
`endif
      default: w_next = FIRST_ST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= FIRST_ST;
      r_i_lo    <= '0;
      r_i_hi    <= '0;
      r_q_first <= '0;
      r_i_din   <= '0;
      r_q_din   <= '0;
    end else if (w_pop) begin
      r_state <= w_next;
      if (r_state == S_I_LO) r_i_lo <= in_dout;
      if (r_state == S_I_HI) r_i_hi <= in_dout;
      if (r_state == Q_FIRST_ST) r_q_first <= in_dout;
      // Last byte bypasses its register and completes both samples directly.
      if (r_state == LAST_ST) begin
        r_i_din <= quantize(w_i_raw);
        r_q_din <= quantize(w_q_raw);
      end
    end else if (w_push) begin
      r_state <= FIRST_ST;
    end
  end

endmodule
